result_checker: RTL and testbench

//  Read-side counterpart of the multiplier test harness. The harness writes products into the result RAM;

---
 rtl/result_checker_pkg.sv | 32 +++
 rtl/result_checker_pipe.sv | 46 ++++
 rtl/result_checker.sv | 205 ++++++++++++++++++++
 tb/tb_result_checker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_checker_pkg.sv
// Shared definitions for the result checker: register map, CTRL bits,
// FSM encoding and a saturating counter helper.
package result_checker_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_COUNT  = 3'd1;
    localparam logic [2:0] REG_BASE   = 3'd2;
    localparam logic [2:0] REG_ERRCNT = 3'd3;
    localparam logic [2:0] REG_FFAIL  = 3'd4;
    localparam logic [2:0] REG_ID     = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_FAIL = 2;

    localparam int FFAIL_VALID = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/result_checker_pipe.sv
// Tag delay line matching the RAM read latency; a flush drops every
// in-flight tag so an aborted check leaves nothing behind.
module check_pipe #(
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  any_valid
);

    logic [RD_LAT-1:0]     vld;
    logic [ADDR_WIDTH-1:0] adr [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                adr[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld <= '0;
            end else begin
                vld[0] <= in_valid;
                for (int i = 1; i < RD_LAT; i++) begin
                    vld[i] <= vld[i-1];
                end
            end
            adr[0] <= in_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                adr[i] <= adr[i-1];
            end
        end
    end

    assign out_valid = vld[RD_LAT-1];
    assign out_addr  = adr[RD_LAT-1];
    assign any_valid = |vld;

endmodule

// File: rtl/result_checker.sv
// Reads an address window from the result and expected RAMs, compares
// them and reports a pass/fail summary over a small Avalon-MM slave.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int ID         = 9,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 9,
    parameter int CMP_WIDTH  = 126,
    parameter int RD_LAT     = 2
) (
    input  logic                  avalon_clk,
    input  logic                  resetn,
    input  logic                  read,
    input  logic                  write,
    input  logic [2:0]            address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] q_res,
    input  logic [DATA_WIDTH-1:0] q_exp,
    output logic                  busy
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [31:0] COUNT_MAX = 32'd1 << ADDR_WIDTH;

    state_t                state;
    state_t                state_nx;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         issue_idx;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [31:0]           errcnt;
    logic                  ffail_valid;
    logic [ADDR_WIDTH-1:0] ffail_addr;
    logic                  done;

    logic                  wr_ctrl;
    logic                  start_go;
    logic                  abort_go;
    logic                  last_issue;
    logic                  issue_valid;
    logic                  cmp_hit;
    logic [CW-1:0]         count_wr;
    logic [31:0]           rdata;

    logic                  pipe_valid;
    logic [ADDR_WIDTH-1:0] pipe_addr;
    logic                  pipe_any;

    assign wr_ctrl  = write && (address == REG_CTRL);
    // Abort dominates: a combined start+abort write never launches a check.
    assign start_go = wr_ctrl && writedata[CTRL_START]
                   && !writedata[CTRL_ABORT]
                   && (state == ST_IDLE || state == ST_DONE);
    assign abort_go = wr_ctrl && writedata[CTRL_ABORT] && busy;

    assign last_issue = (issue_idx == count_q - CW'(1));
    assign count_wr   = (writedata > COUNT_MAX) ? COUNT_MAX[CW-1:0]
                                                : writedata[CW-1:0];

    always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start_go) begin
                    state_nx = (count_q == '0) ? ST_DONE : ST_ISSUE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (abort_go) begin
                    state_nx = ST_IDLE;
                end else if (last_issue) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort_go) begin
                    state_nx = ST_IDLE;
                end else if (!pipe_any) begin
                    state_nx = ST_DONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == ST_ISSUE) || (state == ST_DRAIN);
        issue_valid = (state == ST_ISSUE) && !abort_go;
    end

    check_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RD_LAT     (RD_LAT)
    ) u_pipe (
        .clk       (avalon_clk),
        .rst_n     (resetn),
        .flush     (abort_go),
        .in_valid  (issue_valid),
        .in_addr   (rd_addr),
        .out_valid (pipe_valid),
        .out_addr  (pipe_addr),
        .any_valid (pipe_any)
    );

    assign cmp_hit = pipe_valid && !abort_go
                  && (q_res[CMP_WIDTH-1:0] != q_exp[CMP_WIDTH-1:0]);

    generate
        if (CMP_WIDTH < DATA_WIDTH) begin : g_ignored
            logic unused_hi;
            assign unused_hi = ^{q_res[DATA_WIDTH-1:CMP_WIDTH],
                                 q_exp[DATA_WIDTH-1:CMP_WIDTH]};
        end
    endgenerate

    always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            base_q  <= '0;
        end else if (write && !busy) begin
            if (address == REG_COUNT) begin
                count_q <= count_wr;
            end
            if (address == REG_BASE) begin
                base_q <= writedata[ADDR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) begin
            issue_idx <= '0;
            rd_addr   <= '0;
        end else if (start_go) begin
            issue_idx <= '0;
            if (count_q != '0) begin
                rd_addr <= base_q;
            end
        end else if (issue_valid && !last_issue) begin
            issue_idx <= issue_idx + CW'(1);
            rd_addr   <= rd_addr + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) begin
            done <= 1'b0;
        end else if (state_nx == ST_DONE) begin
            done <= 1'b1;
        end else if (start_go) begin
            done <= 1'b0;
        end
    end

    always_ff @(posedge avalon_clk or negedge resetn) begin
        if (!resetn) begin
            errcnt      <= '0;
            ffail_valid <= 1'b0;
            ffail_addr  <= '0;
        end else if (start_go) begin
            errcnt      <= '0;
            ffail_valid <= 1'b0;
            ffail_addr  <= '0;
        end else if (cmp_hit) begin
            errcnt <= sat_inc(errcnt);
            if (!ffail_valid) begin
                ffail_valid <= 1'b1;
                ffail_addr  <= pipe_addr;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (address)
            REG_CTRL: begin
                rdata[STAT_BUSY] = busy;
                rdata[STAT_DONE] = done;
                rdata[STAT_FAIL] = (errcnt != '0);
            end
            REG_COUNT:  rdata = {{(32-CW){1'b0}}, count_q};
            REG_BASE:   rdata = {{(32-ADDR_WIDTH){1'b0}}, base_q};
            REG_ERRCNT: rdata = errcnt;
            REG_FFAIL:  rdata = {ffail_valid,
                                 {(31-ADDR_WIDTH){1'b0}}, ffail_addr};
            REG_ID:     rdata = 32'(ID);
            default:    rdata = '0;
        endcase
    end

    assign readdata = read ? rdata : '0;

endmodule

// File: tb/tb_result_checker.sv
// Directed and randomized checks of result_checker against a
// window-level reference model of the compare rules.
module tb_result_checker;
    import result_checker_pkg::*;

    localparam int AW    = 9;
    localparam int DW    = 128;
    localparam int CMPW  = 126;
    localparam int RL    = 2;
    localparam int DEPTH = 512;
    localparam logic [DW-1:0] MASK = (128'd1 << CMPW) - 128'd1;

    logic          avalon_clk = 1'b0;
    logic          resetn = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [2:0]    address = '0;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] q_res;
    logic [DW-1:0] q_exp;
    logic          busy;

    result_checker #(
        .ID(9), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .CMP_WIDTH(CMPW), .RD_LAT(RL)
    ) dut (
        .avalon_clk (avalon_clk),
        .resetn     (resetn),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .rd_addr    (rd_addr),
        .q_res      (q_res),
        .q_exp      (q_exp),
        .busy       (busy)
    );

    always #5 avalon_clk = ~avalon_clk;

    logic [DW-1:0] res_mem [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] r1, e1;

    // Two-cycle read latency RAM pair.
    always @(posedge avalon_clk) begin
        r1    <= res_mem[rd_addr];
        e1    <= exp_mem[rd_addr];
        q_res <= r1;
        q_exp <= e1;
    end

    int cyc = 0;
    always @(posedge avalon_clk) cyc <= cyc + 1;

    int            t0 = 0;
    bit            rec_on = 1'b0;
    int            rec_n = 0;
    logic [AW-1:0] addr_q [$];

    always @(negedge avalon_clk) begin
        if (rec_on && (cyc - t0) < rec_n) addr_q.push_back(rd_addr);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic av_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge avalon_clk);
        address = a;
        writedata = d;
        write = 1'b1;
        @(posedge avalon_clk);
        #1;
        write = 1'b0;
    endtask

    task automatic av_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        read = 1'b1;
        #1;
        d = readdata;
        read = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a,
                            input logic [31:0] expv);
        logic [31:0] d;
        av_read(a, d);
        check(tag, d, expv);
    endtask

    task automatic start_run(input int base, input int count);
        rec_on = 1'b0;
        av_write(REG_BASE, 32'(base));
        av_write(REG_COUNT, 32'(count));
        addr_q.delete();
        av_write(REG_CTRL, 32'h1);
        t0 = cyc;
        rec_n = (count > DEPTH) ? DEPTH : count;
        rec_on = 1'b1;
    endtask

    task automatic wait_from_start(input int n);
        while (cyc - t0 < n) begin
            @(posedge avalon_clk);
            #1;
        end
    endtask

    task automatic wait_done(input int budget, output int edges);
        logic [31:0] st;
        forever begin
            av_read(REG_CTRL, st);
            if (st[STAT_DONE] || (cyc - t0) >= budget) break;
            @(posedge avalon_clk);
            #1;
        end
        edges = cyc - t0;
        rec_on = 1'b0;
    endtask

    function automatic void model(input int base, input int count,
                                  output int errs, output logic [31:0] ff);
        int n;
        int a;
        errs = 0;
        ff = '0;
        n = (count > DEPTH) ? DEPTH : count;
        for (int i = 0; i < n; i++) begin
            a = (base + i) % DEPTH;
            if (((res_mem[a] ^ exp_mem[a]) & MASK) != '0) begin
                errs++;
                if (!ff[31]) ff = 32'h8000_0000 | 32'(a);
            end
        end
    endfunction

    task automatic verify(input string tag, input int base, input int count,
                          input longint bias);
        int          errs, edges, n, bad;
        logic [31:0] ff, err_exp;
        longint      tot;
        model(base, count, errs, ff);
        n = (count > DEPTH) ? DEPTH : count;
        wait_done(n + 20, edges);
        check({tag, "/latency"}, 32'(edges),
              (n == 0) ? 32'd0 : 32'(n + RL + 1));
        tot = bias + longint'(errs);
        err_exp = (tot > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : tot[31:0];
        rd_check({tag, "/errcnt"}, REG_ERRCNT, err_exp);
        rd_check({tag, "/ffail"}, REG_FFAIL, ff);
        rd_check({tag, "/ctrl"}, REG_CTRL,
                 {29'd0, err_exp != 0, 1'b1, 1'b0});
        bad = (addr_q.size() != n) ? 1 : 0;
        for (int i = 0; i < n && bad == 0; i++) begin
            if (addr_q[i] != AW'((base + i) % DEPTH)) bad = 1;
        end
        check({tag, "/rd_addr_seq"}, 32'(bad), 32'd0);
    endtask

    task automatic sync_mems();
        for (int a = 0; a < DEPTH; a++) res_mem[a] = exp_mem[a];
    endtask

    initial begin
        logic [AW-1:0] ra;
        int base, count, a, b;

        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        sync_mems();

        repeat (3) @(posedge avalon_clk);
        #1;
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/rd_addr", 32'(rd_addr), 32'd0);
        rd_check("reset/ctrl", REG_CTRL, 32'd0);
        rd_check("reset/count", REG_COUNT, 32'd0);
        rd_check("reset/base", REG_BASE, 32'd0);
        rd_check("reset/errcnt", REG_ERRCNT, 32'd0);
        rd_check("reset/ffail", REG_FFAIL, 32'd0);
        @(negedge avalon_clk);
        resetn = 1'b1;

        rd_check("id", REG_ID, 32'd9);
        av_write(3'd6, 32'hDEAD_BEEF);
        rd_check("reg6", 3'd6, 32'd0);
        rd_check("reg7", 3'd7, 32'd0);
        av_write(REG_COUNT, 32'd1000);
        rd_check("count_clamp", REG_COUNT, 32'd512);
        av_write(REG_COUNT, 32'd300);
        rd_check("count_wr", REG_COUNT, 32'd300);

        start_run(0, 16);
        verify("t1_clean", 0, 16, 0);

        res_mem[5][3]   = ~res_mem[5][3];
        res_mem[9][100] = ~res_mem[9][100];
        start_run(0, 16);
        wait_from_start(7);
        rd_check("t2/errcnt_pre_update", REG_ERRCNT, 32'd0);
        @(posedge avalon_clk);
        #1;
        rd_check("t2/errcnt_post_update", REG_ERRCNT, 32'd1);
        verify("t2_two_errs", 0, 16, 0);
        sync_mems();

        res_mem[511][127] = ~res_mem[511][127];
        res_mem[0][126]   = ~res_mem[0][126];
        start_run(510, 4);
        verify("t3_wrap_ignored", 510, 4, 0);
        sync_mems();

        ra = rd_addr;
        start_run(3, 0);
        verify("t4_zero", 3, 0, 0);
        check("t4/rd_addr_kept", 32'(rd_addr), 32'(ra));
        start_run(0, 100);
        av_write(REG_COUNT, 32'd5);
        av_write(REG_BASE, 32'd7);
        av_write(REG_CTRL, 32'h1);
        rd_check("t4/count_locked", REG_COUNT, 32'd100);
        rd_check("t4/base_locked", REG_BASE, 32'd0);
        verify("t4_busy_start", 0, 100, 0);

        res_mem[2][0]  = ~res_mem[2][0];
        res_mem[50][1] = ~res_mem[50][1];
        start_run(0, 100);
        wait_from_start(9);
        av_write(REG_CTRL, 32'h2);
        rec_on = 1'b0;
        check("t5/busy_after_abort", 32'(busy), 32'd0);
        rd_check("t5/ctrl", REG_CTRL, 32'h4);
        rd_check("t5/errcnt", REG_ERRCNT, 32'd1);
        rd_check("t5/ffail", REG_FFAIL, 32'h8000_0002);
        repeat (6) @(posedge avalon_clk);
        #1;
        rd_check("t5/errcnt_late", REG_ERRCNT, 32'd1);
        start_run(0, 100);
        verify("t5_restart", 0, 100, 0);
        av_write(REG_CTRL, 32'h3);
        check("t5/start_abort_busy", 32'(busy), 32'd0);
        rd_check("t5/start_abort_ctrl", REG_CTRL, 32'h6);

        start_run(0, 50);
        wait_from_start(12);
        @(negedge avalon_clk);
        resetn = 1'b0;
        #1;
        rec_on = 1'b0;
        check("t6/busy", 32'(busy), 32'd0);
        check("t6/rd_addr", 32'(rd_addr), 32'd0);
        rd_check("t6/ctrl", REG_CTRL, 32'd0);
        rd_check("t6/count", REG_COUNT, 32'd0);
        rd_check("t6/base", REG_BASE, 32'd0);
        rd_check("t6/errcnt", REG_ERRCNT, 32'd0);
        rd_check("t6/ffail", REG_FFAIL, 32'd0);
        @(negedge avalon_clk);
        resetn = 1'b1;
        sync_mems();

        for (int i = 100; i < 104; i++) res_mem[i][0] = ~res_mem[i][0];
        start_run(100, 4);
        wait_from_start(1);
        force dut.errcnt = 32'hFFFF_FFFE;
        #1;
        release dut.errcnt;
        verify("t6_saturate", 100, 4, 64'hFFFF_FFFE);
        sync_mems();

        for (int it = 0; it < 6; it++) begin
            base  = $urandom_range(0, DEPTH - 1);
            count = $urandom_range(1, 40);
            for (int k = 0; k < 3; k++) begin
                a = (base + $urandom_range(0, count - 1)) % DEPTH;
                b = $urandom_range(0, DW - 1);
                res_mem[a][b] = ~res_mem[a][b];
            end
            start_run(base, count);
            verify($sformatf("rand%0d", it), base, count, 0);
            sync_mems();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
